// File: rtl/evaluate_taper_if.sv
// Bus between the per-feature evaluators / search logic and the evaluate_taper combiner.
// Carries board start, per-term mg/eg pairs with their valids, and the tapered result.
interface evaluate_taper_if #(
    parameter int EVAL_WIDTH = 16,
    parameter int NUM_TERMS  = 4
) ();
    logic                            board_valid;
    logic                            clear_eval;
    logic [4:0]                      phase;
    logic [NUM_TERMS*EVAL_WIDTH-1:0] term_mg;
    logic [NUM_TERMS*EVAL_WIDTH-1:0] term_eg;
    logic [NUM_TERMS-1:0]            term_valid;
    logic [EVAL_WIDTH-1:0]           eval;
    logic                            eval_valid;

    modport master (
        output board_valid, clear_eval, phase, term_mg, term_eg, term_valid,
        input  eval, eval_valid
    );

    modport slave (
        input  board_valid, clear_eval, phase, term_mg, term_eg, term_valid,
        output eval, eval_valid
    );
endinterface

// File: rtl/evaluate_taper.sv
// Collects NUM_TERMS signed mg/eg pairs, sums them and blends by game phase:
// eval = trunc0((mg*phase + eg*(24-phase)) / 24), saturated to EVAL_WIDTH bits.
module evaluate_taper #(
    parameter int EVAL_WIDTH = 16,
    parameter int NUM_TERMS  = 4
) (
    input logic             clk,
    input logic             reset,
    evaluate_taper_if.slave bus
);
    localparam int SW = EVAL_WIDTH + $clog2(NUM_TERMS);
    localparam int PW = SW + 6;
    localparam int CW = $clog2(PW);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_SUM,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [4:0]            phase_r;
    logic [NUM_TERMS-1:0]  mask;
    logic [EVAL_WIDTH-1:0] mg_lat [NUM_TERMS];
    logic [EVAL_WIDTH-1:0] eg_lat [NUM_TERMS];
    logic [SW-1:0]         mg_sum, eg_sum;
    logic [PW-1:0]         quo;
    logic [4:0]            rem;
    logic                  neg;
    logic [CW-1:0]         cnt;
    logic [EVAL_WIDTH-1:0] eval_r;
    logic                  eval_valid_r;

    logic                  mask_full;
    logic                  div_last;
    logic [SW-1:0]         mg_acc, eg_acc;
    logic [4:0]            phase_eg;
    logic [PW-1:0]         prod, prod_abs;
    logic [5:0]            trial;
    logic                  ge;
    logic [4:0]            rem_next;
    logic [PW-1:0]         quo_next, q_signed;
    logic                  fits;
    logic [EVAL_WIDTH-1:0] eval_next;

    assign bus.eval       = eval_r;
    assign bus.eval_valid = eval_valid_r;

    assign mask_full = &(mask | bus.term_valid);
    assign div_last  = (cnt == CW'(PW - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (bus.clear_eval) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (bus.board_valid) state_next = S_COLLECT;
                S_COLLECT: if (mask_full)       state_next = S_SUM;
                S_SUM:     state_next = S_MUL;
                S_MUL:     state_next = S_DIV;
                S_DIV:     if (div_last)        state_next = S_DONE;
                S_DONE:    state_next = S_DONE;
                default:   state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        mg_acc = '0;
        eg_acc = '0;
        for (int unsigned k = 0; k < NUM_TERMS; k++) begin
            mg_acc = mg_acc + {{(SW-EVAL_WIDTH){mg_lat[k][EVAL_WIDTH-1]}}, mg_lat[k]};
            eg_acc = eg_acc + {{(SW-EVAL_WIDTH){eg_lat[k][EVAL_WIDTH-1]}}, eg_lat[k]};
        end
    end

    // Blend in PW-bit two's complement; the low PW bits of the product are exact.
    always_comb begin
        phase_eg = 5'd24 - phase_r;
        prod     = {{(PW-SW){mg_sum[SW-1]}}, mg_sum} * {{(PW-5){1'b0}}, phase_r}
                 + {{(PW-SW){eg_sum[SW-1]}}, eg_sum} * {{(PW-5){1'b0}}, phase_eg};
        prod_abs = prod[PW-1] ? -prod : prod;
    end

    // One restoring step: remainder stays below 24, so it fits 5 bits between steps.
    always_comb begin
        trial     = {rem, quo[PW-1]};
        ge        = (trial >= 6'd24);
        rem_next  = ge ? 5'(trial - 6'd24) : trial[4:0];
        quo_next  = {quo[PW-2:0], ge};
        q_signed  = neg ? -quo_next : quo_next;
        fits      = (&q_signed[PW-1:EVAL_WIDTH-1]) | ~(|q_signed[PW-1:EVAL_WIDTH-1]);
        eval_next = fits ? q_signed[EVAL_WIDTH-1:0]
                  : (q_signed[PW-1] ? {1'b1, {(EVAL_WIDTH-1){1'b0}}}
                                    : {1'b0, {(EVAL_WIDTH-1){1'b1}}});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_r      <= '0;
            mask         <= '0;
            mg_sum       <= '0;
            eg_sum       <= '0;
            quo          <= '0;
            rem          <= '0;
            neg          <= 1'b0;
            cnt          <= '0;
            eval_r       <= '0;
            eval_valid_r <= 1'b0;
            for (int unsigned k = 0; k < NUM_TERMS; k++) begin
                mg_lat[k] <= '0;
                eg_lat[k] <= '0;
            end
        end else if (bus.clear_eval) begin
            mask         <= '0;
            eval_valid_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.board_valid) begin
                        phase_r <= (bus.phase > 5'd24) ? 5'd24 : bus.phase;
                        mask    <= '0;
                    end
                end
                S_COLLECT: begin
                    for (int unsigned k = 0; k < NUM_TERMS; k++) begin
                        if (bus.term_valid[k] && !mask[k]) begin
                            mg_lat[k] <= bus.term_mg[k*EVAL_WIDTH +: EVAL_WIDTH];
                            eg_lat[k] <= bus.term_eg[k*EVAL_WIDTH +: EVAL_WIDTH];
                            mask[k]   <= 1'b1;
                        end
                    end
                end
                S_SUM: begin
                    mg_sum <= mg_acc;
                    eg_sum <= eg_acc;
                end
                S_MUL: begin
                    quo <= prod_abs;
                    neg <= prod[PW-1];
                    rem <= '0;
                    cnt <= '0;
                end
                S_DIV: begin
                    quo <= quo_next;
                    rem <= rem_next;
                    cnt <= cnt + CW'(1);
                    if (div_last) begin
                        eval_r       <= eval_next;
                        eval_valid_r <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
